// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed digit scanner with a double-buffered display value.
// Optional feature: define SEG_SCAN_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] value,
    input  logic [NUM_DIGITS-1:0]            blank_mask,
    output logic [DATA_WIDTH-1:0]            digit_data,
    output logic [NUM_DIGITS-1:0]            an,
    output logic                             frame_start,
    output logic                             pending
);
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = NUM_DIGITS * DATA_WIDTH;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [PS_W-1:0]       prescaler;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      active;
    logic [VAL_W-1:0]      shadow;
    logic                  tick;
    logic                  wrap;
    logic                  auto_blank;
    logic [DATA_WIDTH-1:0] digits [NUM_DIGITS];

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // active only changes on the wrap tick, so a frame never mixes old and new digits
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            prescaler   <= tick ? '0 : prescaler + PS_ONE;
            frame_start <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + IDX_ONE;
            end
            if (load && wrap) begin
                active  <= value;
                shadow  <= value;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (wrap && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = active[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // zero_above[i]: digit i and every more-significant digit are zero
    logic [NUM_DIGITS-1:0] zero_above;

    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (digits[i] == '0);
        end
    end

    assign auto_blank = (idx != '0) && zero_above[idx];
`else
    assign auto_blank = 1'b0;
`endif

    assign digit_data = digits[idx];

    always_comb begin
        // NOTE: default first so no path leaves an unassigned (no latch).
        an = '1;
        if (!(blank_mask[idx] || auto_blank)) begin
            an[idx] = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed vector table plus randomized run against a time-based reference model.
// Build with SEG_SCAN_LEADING_ZERO_BLANK_EN defined to check leading-zero blanking.
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int RD = 4;
    localparam int W  = N * DW;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  value = '0;
    logic [N-1:0]  blank_mask = '0;
    logic [DW-1:0] digit_data;
    logic [N-1:0]  an;
    logic          frame_start;
    logic          pending;

    seg_scan_mux #(.NUM_DIGITS(N), .DATA_WIDTH(DW), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .digit_data(digit_data), .an(an), .frame_start(frame_start), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, got, exp, t, $time);
        end
    endtask

    // Reference model: position derived from cycles elapsed since reset.
    int           t = 0;
    logic [W-1:0] m_active = '0;
    logic [W-1:0] m_shadow = '0;
    bit           m_pending = 1'b0;
    bit           m_fs = 1'b0;

    task automatic model_edge();
        bit wrap;
        if (rst) begin
            t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_fs = 1'b0;
        end else begin
            wrap = (t % RD == RD - 1) && ((t / RD) % N == N - 1);
            if (load && wrap) begin
                m_active = value; m_shadow = value; m_pending = 1'b0;
            end else if (load) begin
                m_shadow = value; m_pending = 1'b1;
            end else if (wrap && m_pending) begin
                m_active = m_shadow; m_pending = 1'b0;
            end
            m_fs = wrap;
            t++;
        end
    endtask

    task automatic model_check();
        int       i;
        bit       dark;
        logic [N-1:0] exp_an;
        i    = (t / RD) % N;
        dark = blank_mask[i];
        if (LZ && i > 0 && (m_active >> (DW * i)) == '0) dark = 1'b1;
        exp_an = dark ? {N{1'b1}} : ~(N'(1) << i);
        check("model_an", 32'(an), 32'(exp_an));
        check("model_digit_data", 32'(digit_data), 32'((m_active >> (DW * i)) & ((1 << DW) - 1)));
        check("model_frame_start", 32'(frame_start), 32'(m_fs));
        check("model_pending", 32'(pending), 32'(m_pending));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        string        name;
        int           idle;
        bit           rst;
        bit           load;
        logic [W-1:0] value;
        logic [N-1:0] blank;
        logic [N-1:0] exp_an;
        logic [DW-1:0] exp_dd;
        bit           exp_fs;
        bit           exp_pend;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"reset",           0, 1, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"slot0_end",       2, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"slot1_start",     0, 0, 0, 16'h0000, 4'b0000, 4'b1101, 4'h0, 0, 0});
        vecs.push_back('{"first_wrap",     11, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 1, 0});
        vecs.push_back('{"fs_one_cycle",    0, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"load_idx1",       3, 0, 1, 16'h1234, 4'b0000, 4'b1101, 4'h0, 0, 1});
        vecs.push_back('{"held_to_wrap",    9, 0, 0, 16'h0000, 4'b0000, 4'b0111, 4'h0, 0, 1});
        vecs.push_back('{"commit_d0",       0, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h4, 1, 0});
        vecs.push_back('{"commit_d1",       3, 0, 0, 16'h0000, 4'b0000, 4'b1101, 4'h3, 0, 0});
        vecs.push_back('{"commit_d2",       3, 0, 0, 16'h0000, 4'b0000, 4'b1011, 4'h2, 0, 0});
        vecs.push_back('{"commit_d3",       3, 0, 0, 16'h0000, 4'b0000, 4'b0111, 4'h1, 0, 0});
        vecs.push_back('{"load_on_wrap",    3, 0, 1, 16'hABCD, 4'b0000, 4'b1110, 4'hD, 1, 0});
        vecs.push_back('{"blank_idx2",      7, 0, 0, 16'h0000, 4'b0100, 4'b1111, 4'hB, 0, 0});
        vecs.push_back('{"blank_idx3_lit",  3, 0, 0, 16'h0000, 4'b0100, 4'b0111, 4'hA, 0, 0});
        vecs.push_back('{"load_0042",       0, 0, 1, 16'h0042, 4'b0000, 4'b0111, 4'hA, 0, 1});
        vecs.push_back('{"lz_d0",           2, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h2, 1, 0});
        vecs.push_back('{"lz_d1",           3, 0, 0, 16'h0000, 4'b0000, 4'b1101, 4'h4, 0, 0});
        vecs.push_back('{"lz_d2",           3, 0, 0, 16'h0000, 4'b0000, LZ ? 4'b1111 : 4'b1011, 4'h0, 0, 0});
        vecs.push_back('{"lz_d3",           3, 0, 0, 16'h0000, 4'b0000, LZ ? 4'b1111 : 4'b0111, 4'h0, 0, 0});
        vecs.push_back('{"zero_d0",         3, 0, 1, 16'h0000, 4'b0000, 4'b1110, 4'h0, 1, 0});
        vecs.push_back('{"zero_d1",         3, 0, 0, 16'h0000, 4'b0000, LZ ? 4'b1111 : 4'b1101, 4'h0, 0, 0});
        vecs.push_back('{"load_5678",       0, 0, 1, 16'h5678, 4'b0000, LZ ? 4'b1111 : 4'b1101, 4'h0, 0, 1});
        vecs.push_back('{"rst_idx2_pend",   3, 1, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"rst_beats_load",  0, 1, 1, 16'hFFFF, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"post_rst_slot0",  2, 0, 0, 16'h0000, 4'b0000, 4'b1110, 4'h0, 0, 0});
        vecs.push_back('{"post_rst_slot1",  0, 0, 0, 16'h0000, 4'b0000, 4'b1101, 4'h0, 0, 0});

        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].idle; j++) begin
                rst = 1'b0; load = 1'b0; blank_mask = vecs[k].blank;
                step();
            end
            rst = vecs[k].rst; load = vecs[k].load; value = vecs[k].value; blank_mask = vecs[k].blank;
            step();
            check({vecs[k].name, "_an"}, 32'(an), 32'(vecs[k].exp_an));
            check({vecs[k].name, "_dd"}, 32'(digit_data), 32'(vecs[k].exp_dd));
            check({vecs[k].name, "_fs"}, 32'(frame_start), 32'(vecs[k].exp_fs));
            check({vecs[k].name, "_pend"}, 32'(pending), 32'(vecs[k].exp_pend));
            rst = 1'b0; load = 1'b0;
        end

        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] mask;
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            rst        = ($urandom_range(0, 99) == 0);
            load       = ($urandom_range(0, 5) == 0);
            value      = W'($urandom) & mask;
            blank_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
